multicycle_controller: RTL and testbench

- Main control FSM plus ALU decoder for the multicycle MIPS datapath.
- Replaces the single-cycle control decode. Sequences each instruction through fetch, decode, execute, memory and writeback cycles, one state per clock.
- Drives the datapath's mux selects, write enables and ALU control from the instruction opcode/funct fields and the ALU Zero flag.

---
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction fields, flags and control lines between controller and datapath
interface multicycle_controller_if #(
    parameter int STATE_W = 4
);
    logic [5:0]         Op;
    logic [5:0]         Funct;
    logic               Zero;
    logic               IorD;
    logic               MemWrite;
    logic               IRWrite;
    logic               RegDst;
    logic               MemtoReg;
    logic               RegWrite;
    logic               ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         PCSrc;
    logic [2:0]         ALUControl;
    logic               PCEn;
    logic               Illegal;
    logic [STATE_W-1:0] State;

    modport master (
        input  Op, Funct, Zero,
        output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, PCEn, Illegal, State
    );

    modport slave (
        output Op, Funct, Zero,
        input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, PCSrc, ALUControl, PCEn, Illegal, State
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle MIPS main control FSM and ALU decoder
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t     state_q;
    state_t     state_d;
    state_t     out_state;
    logic       store_q;
    logic       op_legal;
    logic       pc_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       illegal;

    // State register; the lw/sw choice is captured in DECODE so Op is free to change afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                store_q <= (bus.Op == OP_SW);
            end
        end
    end

    // Next-state sequencing through the instruction phases
    always_comb begin
        state_d  = FETCH;
        op_legal = 1'b1;
        case (state_q)
            FETCH:    state_d = DECODE;
            DECODE: begin
                case (bus.Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEXEC;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d  = FETCH;
                        op_legal = 1'b0;
                    end
                endcase
            end
            MEMADR:   state_d = store_q ? MEMWR : MEMRD;
            MEMRD:    state_d = MEMWB;
            EXECUTE:  state_d = ALUWB;
            ADDIEXEC: state_d = ADDIWB;
            default:  state_d = FETCH;
        endcase
    end

    // Moore output decode; during reset the FETCH pattern is shown with all write strobes suppressed
    always_comb begin
        out_state    = reset ? FETCH : state_q;
        bus.IorD     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        bus.RegDst   = 1'b0;
        bus.MemtoReg = 1'b0;
        reg_write    = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.PCSrc    = 2'b00;
        alu_op       = 2'b00;
        pc_write     = 1'b0;
        branch       = 1'b0;
        illegal      = 1'b0;
        case (out_state)
            FETCH: begin
                ir_write    = 1'b1;
                bus.ALUSrcB = 2'b01;
                pc_write    = 1'b1;
            end
            DECODE: begin
                bus.ALUSrcB = 2'b11;
                illegal     = ~op_legal;
            end
            MEMADR, ADDIEXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end
            MEMRD:    bus.IorD = 1'b1;
            MEMWB: begin
                bus.MemtoReg = 1'b1;
                reg_write    = 1'b1;
            end
            MEMWR: begin
                bus.IorD  = 1'b1;
                mem_write = 1'b1;
            end
            EXECUTE: begin
                bus.ALUSrcA = 1'b1;
                alu_op      = 2'b10;
            end
            ALUWB: begin
                bus.RegDst = 1'b1;
                reg_write  = 1'b1;
            end
            BRANCH: begin
                bus.ALUSrcA = 1'b1;
                alu_op      = 2'b01;
                bus.PCSrc   = 2'b01;
                branch      = 1'b1;
            end
            ADDIWB:   reg_write = 1'b1;
            JUMP: begin
                bus.PCSrc = 2'b10;
                pc_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: fixed add/sub unless EXECUTE asks for the R-type function field
    always_comb begin
        bus.ALUControl = 3'b010;
        case (alu_op)
            2'b01: bus.ALUControl = 3'b110;
            2'b10: begin
                case (bus.Funct)
                    6'b100010: bus.ALUControl = 3'b110;
                    6'b100100: bus.ALUControl = 3'b000;
                    6'b100101: bus.ALUControl = 3'b001;
                    6'b101010: bus.ALUControl = 3'b111;
                    default:   bus.ALUControl = 3'b010;
                endcase
            end
            default: bus.ALUControl = 3'b010;
        endcase
    end

    assign bus.MemWrite = mem_write & ~reset;
    assign bus.IRWrite  = ir_write  & ~reset;
    assign bus.RegWrite = reg_write & ~reset;
    assign bus.Illegal  = illegal   & ~reset;
    assign bus.PCEn     = (pc_write | (branch & bus.Zero)) & ~reset;
    assign bus.State    = STATE_W'(out_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - randomized model-checked bench for multicycle_controller
module tb_multicycle_controller;

    typedef struct packed {
        logic       IorD;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegDst;
        logic       MemtoReg;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] PCSrc;
        logic [2:0] ALUControl;
        logic       PCEn;
        logic       Illegal;
        logic [3:0] State;
    } outs_t;

    typedef int iq_t[$];

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, JMP = 6'b000010;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    outs_t seen [16];
    outs_t last;
    int   obs_code;

    multicycle_controller_if #(.STATE_W(4)) bus ();

    multicycle_controller #(.STATE_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    function automatic bit is_legal(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
    endfunction

    // States visited from FETCH up to (not including) the next FETCH
    function automatic iq_t exp_seq(input logic [5:0] op);
        iq_t q;
        case (op)
            LW:      q = '{0, 1, 2, 3, 4};
            SW:      q = '{0, 1, 2, 5};
            RT:      q = '{0, 1, 6, 7};
            BEQ:     q = '{0, 1, 8};
            ADDI:    q = '{0, 1, 9, 10};
            JMP:     q = '{0, 1, 11};
            default: q = '{0, 1};
        endcase
        return q;
    endfunction

    function automatic logic [2:0] funct_op(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Required outputs for a given architectural state and inputs
    function automatic outs_t model(input int st, input logic rst, input logic [5:0] op,
                                    input logic [5:0] fn, input logic z);
        outs_t o;
        int    s;
        int    aluop;
        bit    pcw;
        bit    br;
        o = '0; aluop = 0; pcw = 0; br = 0;
        s = rst ? 0 : st;
        o.State = 4'(s);
        case (s)
            0:  begin o.IRWrite = 1; o.ALUSrcB = 2'b01; pcw = 1; end
            1:  begin o.ALUSrcB = 2'b11; o.Illegal = !is_legal(op); end
            2:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            3:  o.IorD = 1;
            4:  begin o.MemtoReg = 1; o.RegWrite = 1; end
            5:  begin o.IorD = 1; o.MemWrite = 1; end
            6:  begin o.ALUSrcA = 1; aluop = 2; end
            7:  begin o.RegDst = 1; o.RegWrite = 1; end
            8:  begin o.ALUSrcA = 1; aluop = 1; o.PCSrc = 2'b01; br = 1; end
            9:  begin o.ALUSrcA = 1; o.ALUSrcB = 2'b10; end
            10: o.RegWrite = 1;
            11: begin o.PCSrc = 2'b10; pcw = 1; end
            default: ;
        endcase
        o.ALUControl = (aluop == 0) ? 3'b010 : (aluop == 1) ? 3'b110 : funct_op(fn);
        o.PCEn = pcw | (br & z);
        if (rst) begin
            o.MemWrite = 0; o.IRWrite = 0; o.RegWrite = 0; o.PCEn = 0; o.Illegal = 0;
        end
        return o;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the falling edge, compare all outputs before the rising edge
    task automatic cycle(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input int st);
        outs_t exp;
        outs_t act;
        @(negedge clk);
        reset = rst; bus.Op = op; bus.Funct = fn; bus.Zero = z;
        #2;
        exp = model(st, rst, op, fn, z);
        act = '{bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst, bus.MemtoReg, bus.RegWrite,
                bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc, bus.ALUControl, bus.PCEn, bus.Illegal,
                bus.State};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cyc t=%0t st=%0d rst=%0b op=%b: got %h expected %h",
                     $time, st, rst, op, act, exp);
        end
        last = act;
        seen[act.State] = act;
        obs_code = (obs_code << 4) | int'(act.State);
    endtask

    // zmode 0/1 fixes Zero, 2 randomizes it; abort_at is the cycle index where reset hits (-1 none)
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input bit scramble, input int abort_at);
        iq_t       seq;
        logic [5:0] o;
        logic [5:0] f;
        logic      z;
        seq = exp_seq(op);
        obs_code = 0;
        for (int k = 0; k < seq.size(); k++) begin
            o = op; f = fn;
            if (scramble && seq[k] != 1 && seq[k] != 6) begin
                o = 6'($urandom); f = 6'($urandom);
            end
            z = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            cycle(k == abort_at, o, f, z, seq[k]);
            if (k == abort_at) break;
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        int         cls;
        int         ab;
        reset = 1'b1; bus.Op = LW; bus.Funct = '0; bus.Zero = 1'b0;

        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, LW, 6'd0, 1'b1, 0);
            chk("rst_state", int'(last.State), 0);
            chk("rst_pcen", int'(last.PCEn), 0);
            chk("rst_irwrite", int'(last.IRWrite), 0);
        end

        run_instr(LW, 6'd0, 0, 1'b0, -1);
        chk("lw_seq", obs_code, 'h01234);
        chk("fetch_irwrite", int'(seen[0].IRWrite), 1);
        chk("fetch_pcen", int'(seen[0].PCEn), 1);
        chk("fetch_aluctl", int'(seen[0].ALUControl), 'b010);
        chk("lw_iord", int'(seen[3].IorD), 1);
        chk("lw_wb", int'({seen[4].RegWrite, seen[4].MemtoReg, seen[4].RegDst}), 'b110);

        run_instr(RT, 6'b101010, 0, 1'b0, -1);
        chk("slt_seq", obs_code, 'h0167);
        chk("slt_aluctl", int'(seen[6].ALUControl), 'b111);
        chk("slt_wb", int'({seen[7].RegWrite, seen[7].RegDst}), 'b11);

        run_instr(BEQ, 6'd0, 1, 1'b0, -1);
        chk("beq_z1_seq", obs_code, 'h018);
        chk("beq_z1", int'({seen[8].ALUControl, seen[8].PCSrc, seen[8].PCEn}), 'b110011);
        run_instr(BEQ, 6'd0, 0, 1'b0, -1);
        chk("beq_z0_seq", obs_code, 'h018);
        chk("beq_z0", int'({seen[8].ALUControl, seen[8].PCSrc, seen[8].PCEn}), 'b110010);

        run_instr(6'b111111, 6'd0, 0, 1'b0, -1);
        chk("ill_seq", obs_code, 'h01);
        chk("ill_flag", int'(seen[1].Illegal), 1);
        chk("ill_fetch", int'(seen[0].Illegal), 0);

        run_instr(SW, 6'd0, 0, 1'b0, 3);
        chk("sw_abort_memwrite", int'(last.MemWrite), 0);
        chk("sw_abort_state", int'(last.State), 0);

        run_instr(SW, 6'd0, 0, 1'b1, -1);
        chk("sw_seq", obs_code, 'h0125);
        chk("sw_memwrite", int'(seen[5].MemWrite), 1);

        for (int n = 0; n < 400; n++) begin
            cls = $urandom_range(0, 6);
            case (cls)
                0: op = LW;
                1: op = SW;
                2: op = RT;
                3: op = BEQ;
                4: op = ADDI;
                5: op = JMP;
                default: begin
                    op = 6'($urandom);
                    while (is_legal(op)) op = 6'($urandom);
                end
            endcase
            case ($urandom_range(0, 5))
                0: fn = 6'b100000;
                1: fn = 6'b100010;
                2: fn = 6'b100100;
                3: fn = 6'b100101;
                4: fn = 6'b101010;
                default: fn = 6'($urandom);
            endcase
            ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(op, fn, 2, 1'b1, ab);
        end

        cycle(1'b0, 6'($urandom), 6'($urandom), 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
